// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, the NOP
// encoding presented while the IF/ID register is empty, and the
// {instr, pc} pair that travels through the skid buffer and output register.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer. It catches an instruction that returns from memory
// while IF/ID is stalled and already holds a live instruction.
// Priority: clear (redirect) > load > unload. A simultaneous load and unload
// leaves the buffer full with the new entry.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         full,
    output fetch_entry_t dout
);

    // Occupancy flag and payload register.
    // NOTE: state is written with <= so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            full <= 1'b0;
            // NOTE: the payload is reset as well so a cleared buffer never exposes X on dout.
            dout <= '{instr: NOP_INSTR, pc: 32'h0000_0000};
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for the 5-stage MIPS pipeline.
// Owns the PC, runs a single-outstanding req/gnt/rvalid handshake with
// instruction memory, and presents {instr, pc, pc+4} to IF/ID. A one-entry
// skid buffer absorbs the ID stall; a redirect from ID squashes any
// wrong-path fetch still in flight.
// Optional feature: define FETCH_PERF_EN to add the perf_fetch_cnt and
// perf_squash_cnt counter outputs.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        id_stall,
    input  logic        id_shouldJumpOrBranch,
    input  logic [31:0] id_jumpOrBranchPc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_squash_cnt
`endif
);

    fetch_state_t state;
    logic [31:0]  inflight_pc;

    logic         redirect;
    logic         granted;
    logic         rsp_live;
    logic         rsp_to_out;
    logic         out_load;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_full;
    fetch_entry_t rsp_entry;
    fetch_entry_t skid_dout;
    fetch_entry_t out_src;

    assign redirect  = id_shouldJumpOrBranch;
    // Decoded from registered state only; no request while the skid is occupied.
    assign imem_req  = (state == REQ) && !skid_full;
    assign imem_addr = pc;
    assign granted   = imem_req && imem_gnt;
    assign rsp_entry = '{instr: imem_rdata, pc: inflight_pc};

    // Steer the returning word and the skid buffer toward the output register.
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    always_comb begin
        rsp_live    = (state == WAIT) && imem_rvalid && !redirect;
        rsp_to_out  = rsp_live && !skid_full && (!if_valid || !id_stall);
        skid_unload = !redirect && !id_stall && skid_full;
        skid_load   = rsp_live && !rsp_to_out;
        out_load    = skid_unload || rsp_to_out;
        out_src     = skid_unload ? skid_dout : rsp_entry;
    end

    fetch_skid_buf u_skid (
        .clock  (clock),
        .resetn (resetn),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (redirect),
        .din    (rsp_entry),
        .full   (skid_full),
        .dout   (skid_dout)
    );

    // FSM, PC and IF/ID output register; a redirect overrides everything.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight_pc <= 32'h0000_0000;
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= 32'h0000_0000;
            if_pc_4     <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (granted) begin
                        inflight_pc <= pc;
                        state       <= redirect ? FLUSH : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid)   state <= REQ;
                    else if (redirect) state <= FLUSH;
                end
                // The in-flight word is dropped whenever it shows up, even in the
                // same cycle as a further redirect; waiting for another rvalid
                // there would never end.
                FLUSH: if (imem_rvalid) state <= REQ;
                default: state <= IDLE;
            endcase

            if (redirect)     pc <= id_jumpOrBranchPc;
            else if (granted) pc <= pc + 32'd4;

            if (redirect) begin
                if_valid <= 1'b0;
            end else if (out_load) begin
                if_valid <= 1'b1;
                if_instr <= out_src.instr;
                if_pc    <= out_src.pc;
                if_pc_4  <= out_src.pc + 32'd4;
            end else if (!id_stall) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic       discard_rvalid;
    logic [1:0] squash_inc;

    // An entry already accepted by ID (if_valid with no stall) is not squashed.
    assign discard_rvalid = imem_rvalid && ((state == FLUSH) || ((state == WAIT) && redirect));
    assign squash_inc     = {1'b0, discard_rvalid}
                          + {1'b0, redirect && if_valid && id_stall}
                          + {1'b0, redirect && skid_full};

    // Free-running wrapping event counters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_fetch_cnt  <= 32'h0000_0000;
            perf_squash_cnt <= 32'h0000_0000;
        end else begin
            if (granted) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            perf_squash_cnt <= perf_squash_cnt + {30'd0, squash_inc};
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural instruction memory,
// a scoreboard of instructions expected at IF/ID, and directed phases for
// stall, redirect, PC wrap and mid-transaction reset.
`timescale 1ns/1ps
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        resetn;
    logic        id_stall;
    logic        id_shouldJumpOrBranch;
    logic [31:0] id_jumpOrBranchPc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_squash_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Memory model knobs and state
    bit          gnt_en;
    int          rsp_delay;
    bit          mem_pending;
    int          mem_wait;
    logic [31:0] mem_addr;
    logic [31:0] gnt_addr;

    // Scoreboard state
    fetch_entry_t sb[$];
    int           epoch = 0;
    bit           g_valid = 1'b0;
    int           g_epoch;
    logic [31:0]  g_addr;
    logic [31:0]  m_fetch = 0;
    logic [31:0]  m_squash = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clock                 (clock),
        .resetn                (resetn),
        .id_stall              (id_stall),
        .id_shouldJumpOrBranch (id_shouldJumpOrBranch),
        .id_jumpOrBranchPc     (id_jumpOrBranchPc),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_gnt              (imem_gnt),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .pc                    (pc),
        .if_valid              (if_valid),
        .if_instr              (if_instr),
        .if_pc                 (if_pc),
        .if_pc_4               (if_pc_4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt        (perf_fetch_cnt),
        .perf_squash_cnt       (perf_squash_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0000};
    endfunction

    function automatic logic [31:0] sb_head_pc();
        return (sb.size() != 0) ? sb[0].pc : 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            if (if_valid) break;
            step();
        end
        check("tmo_valid", if_valid, 1);
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 40; i++) begin
            if (imem_gnt) break;
            step();
        end
        check("tmo_gnt", imem_gnt, 1);
    endtask

    // Instruction memory: gnt with req in the same cycle, rvalid rsp_delay
    // cycles after the cycle following the grant.
    always @(posedge clock) begin
        #1;
        if (imem_gnt) begin
            mem_pending = 1'b1;
            mem_addr    = gnt_addr;
            mem_wait    = rsp_delay;
        end
        imem_rvalid = 1'b0;
        if (mem_pending) begin
            if (mem_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_pending = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        imem_gnt = gnt_en && imem_req && !mem_pending;
        gnt_addr = imem_addr;
    end

    // Scoreboard: values at the negedge are what the next rising edge samples.
    always @(negedge clock) begin
        if (!resetn) begin
            sb.delete();
            epoch++;
            g_valid  = 1'b0;
            m_fetch  = 0;
            m_squash = 0;
        end else begin
            if (if_valid && !id_stall) begin
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    fetch_entry_t e;
                    e = sb.pop_front();
                    check("sb_instr", if_instr, e.instr);
                    check("sb_pc", if_pc, e.pc);
                    check("sb_pc_4", if_pc_4, e.pc + 32'd4);
                end
            end
            if (imem_rvalid && g_valid) begin
                g_valid = 1'b0;
                if (g_epoch == epoch && !id_shouldJumpOrBranch)
                    sb.push_back('{instr: mem_word(g_addr), pc: g_addr});
                else
                    m_squash++;
            end
            if (imem_req && imem_gnt) begin
                g_valid = 1'b1;
                g_addr  = imem_addr;
                g_epoch = epoch;
                m_fetch++;
            end
            if (id_shouldJumpOrBranch) begin
                m_squash += 32'(sb.size());
                sb.delete();
                epoch++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; id_stall = 1'b0; id_shouldJumpOrBranch = 1'b0;
        id_jumpOrBranchPc = 32'h0; gnt_en = 1'b1; rsp_delay = 0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        mem_pending = 1'b0; mem_wait = 0;

        // Reset values
        step(); step();
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_instr", if_instr, NOP_INSTR);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_pc_4", if_pc_4, 0);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        resetn = 1'b1;
        check("idle_req", imem_req, 0);

        // Streaming at peak rate: req on odd cycles, if_valid every second cycle
        for (int k = 1; k <= 6; k++) begin
            step();
            check("p1_valid", if_valid, 32'(k >= 3 && k % 2 == 1));
            if (k % 2 == 1) begin
                check("p1_req", imem_req, 1);
                check("p1_addr", imem_addr, 32'((k - 1) * 2));
            end else begin
                check("p1_req_wait", imem_req, 0);
            end
            if (k >= 3 && k % 2 == 1) begin
                check("p1_if_pc", if_pc, 32'((k - 3) * 2));
                check("p1_if_pc_4", if_pc_4, 32'((k - 3) * 2 + 4));
            end
        end

        // ID stall for 5 cycles: output holds, next word lands in the skid
        wait_valid();
        id_stall = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            step();
            check("stall_valid", if_valid, 1);
            check("stall_hold_pc", if_pc, sb_head_pc());
            check("stall_req", imem_req, 0);
        end
        id_stall = 1'b0;
        step();
        check("skid_out_valid", if_valid, 1);
        check("skid_out_pc", if_pc, 32'hC);
        check("skid_req_resume", imem_req, 1);

        // Redirect in WAIT before rvalid: word discarded, fetch from 0x100
        rsp_delay = 1;
        wait_gnt();
        step();
        id_shouldJumpOrBranch = 1'b1; id_jumpOrBranchPc = 32'h100;
        step();
        id_shouldJumpOrBranch = 1'b0;
        check("rw_flush_req", imem_req, 0);
        check("rw_addr", imem_addr, 32'h100);
        rsp_delay = 0;
        step();
        check("rw_req", imem_req, 1);
        check("rw_req_addr", imem_addr, 32'h100);
        wait_valid();
        check("rw_if_pc", if_pc, 32'h100);

        // Redirect in WAIT coinciding with rvalid
        wait_gnt();
        step();
        id_shouldJumpOrBranch = 1'b1; id_jumpOrBranchPc = 32'h180;
        step();
        id_shouldJumpOrBranch = 1'b0;
        check("rv_req", imem_req, 1);
        check("rv_addr", imem_addr, 32'h180);
        wait_valid();
        check("rv_if_pc", if_pc, 32'h180);

        // Redirect in REQ with gnt withheld, then REQ+gnt, then again in FLUSH
        gnt_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && !imem_gnt) break;
            step();
        end
        check("rq_req_held", imem_req, 1);
        id_shouldJumpOrBranch = 1'b1; id_jumpOrBranchPc = 32'h300;
        step();
        id_shouldJumpOrBranch = 1'b0;
        check("rq_stay_req", imem_req, 1);
        check("rq_addr", imem_addr, 32'h300);
        rsp_delay = 2; gnt_en = 1'b1;
        step();
        check("rq_gnt", imem_gnt, 1);
        id_shouldJumpOrBranch = 1'b1; id_jumpOrBranchPc = 32'h400;
        step();
        check("rq_flush_req", imem_req, 0);
        id_jumpOrBranchPc = 32'h200;
        rsp_delay = 0;
        step();
        id_shouldJumpOrBranch = 1'b0;
        check("rf_req", imem_req, 0);
        check("rf_addr", imem_addr, 32'h200);
        wait_gnt();
        check("rf_gnt_addr", imem_addr, 32'h200);
        wait_valid();
        check("rf_if_pc", if_pc, 32'h200);

        // PC wrap at 2^32
        id_shouldJumpOrBranch = 1'b1; id_jumpOrBranchPc = 32'hFFFF_FFFC;
        step();
        id_shouldJumpOrBranch = 1'b0;
        wait_gnt();
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_next_addr", imem_addr, 32'h0);
        wait_valid();
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_if_pc_4", if_pc_4, 32'h0);
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_squash", perf_squash_cnt, m_squash);
`endif

        // Reset asserted in WAIT; stale rvalid arrives in IDLE
        rsp_delay = 1;
        wait_gnt();
        step();
        resetn = 1'b0;
        #1;
        check("mr_req", imem_req, 0);
        check("mr_valid", if_valid, 0);
        check("mr_instr", if_instr, NOP_INSTR);
        check("mr_if_pc", if_pc, 0);
        check("mr_if_pc_4", if_pc_4, 0);
        check("mr_pc", pc, 32'h0);
        check("mr_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        check("mr_perf_fetch", perf_fetch_cnt, 0);
        check("mr_perf_squash", perf_squash_cnt, 0);
`endif
        rsp_delay = 0;
        step();
        resetn = 1'b1;
        step();
        check("mr_restart_req", imem_req, 1);
        check("mr_restart_addr", imem_addr, 32'h0);
        wait_valid();
        check("mr_if_pc", if_pc, 32'h0);
        check("mr_if_instr", if_instr, mem_word(32'h0));

        repeat (6) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
